// File: rtl/imem_loader.sv
// Program-load stage: receives a 16-byte program plus checksum over a
// valid/ready byte stream, stores it in a writable instruction store, serves
// combinational fetch, and gates the core's run enable on a good checksum.
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          host_valid,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] instr_out,
  output logic          cpu_run,
  output logic          load_done,
  output logic          load_err,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   csum, csum_nxt;
  logic            wr_en;
  logic            xfer;
  logic [DW-1:0]   store [DEPTH];

  // Running checksum add; the carry out of the byte is intentionally dropped.
  function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    return a + b;
  endfunction

  // A byte moves only when the host offers it and the loader is accepting.
  assign xfer = host_valid && host_ready;

  // Next-state, counter, checksum and write-enable decode; start overrides all.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    csum_nxt  = csum;
    wr_en     = 1'b0;
    if (start) begin
      state_nxt = S_LOAD;
      cnt_nxt   = '0;
      csum_nxt  = '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (xfer) begin
            wr_en    = 1'b1;
            cnt_nxt  = cnt + AW'(1);
            csum_nxt = add_mod(csum, host_data);
            if (cnt == AW'(DEPTH - 1)) state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (xfer) state_nxt = (host_data == csum) ? S_RUN : S_ERROR;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      csum  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      csum  <= csum_nxt;
    end
  end

  // Instruction store: cleared on reset, written one byte per program transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (wr_en) begin
      store[cnt] <= host_data;
    end
  end

  // Status outputs decode purely from the state register.
  assign host_ready = (state == S_LOAD) || (state == S_CHECK);
  assign cpu_run    = (state == S_RUN);
  assign load_done  = (state == S_RUN);
  assign load_err   = (state == S_ERROR);
  assign checksum   = csum;

  // Fetch returns a NOP (ADD R0,R0 = 8'h00) unless the program is validated.
  assign instr_out  = (state == S_RUN) ? store[fetch_addr] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of program loads plus hand-written
// sequences for reset, restart, reload and stall behaviour.
module tb_imem_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] instr_out;
  logic          cpu_run;
  logic          load_done;
  logic          load_err;
  logic [DW-1:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0] prog;
    logic [7:0]   cbyte;
    bit           stall;
    bit           exp_run;
    logic [7:0]   exp_csum;
  } vec_t;

  vec_t vecs [4];

  // Sum of these bytes mod 256 is 8'h1F.
  logic [7:0] good_bytes [16] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h44, 8'h64, 8'h70, 8'h22,
                                  8'h01, 8'h13, 8'h31, 8'h42, 8'h23, 8'h11, 8'h70, 8'h50};

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .fetch_addr (fetch_addr),
    .instr_out  (instr_out),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_err   (load_err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one byte, optionally preceded by a few idle (valid low) cycles.
  task automatic send(input logic [7:0] b, input bit stall);
    int n;
    logic [7:0] held;
    n = 0;
    while (stall && n < 4 && $urandom_range(0, 1) == 1) begin
      host_valid = 1'b0;
      host_data  = 8'hAA;
      held       = checksum;
      tick;
      chk("stall_hold", checksum, held);
      n++;
    end
    host_valid = 1'b1;
    host_data  = b;
    tick;
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({name, "_ready"}, host_ready, 1);
    chk({name, "_csum0"}, checksum, 0);
    chk({name, "_run0"}, {cpu_run, load_done, load_err}, 0);
    chk({name, "_instr0"}, instr_out, 0);
  endtask

  // 16 program bytes then the checksum byte, followed by status and fetch checks.
  task automatic load_body(input vec_t v, input int idx);
    for (int i = 0; i < 16; i++) send(v.prog[i*8 +: 8], v.stall);
    chk($sformatf("v%0d_check_state", idx), {host_ready, cpu_run}, 2'b10);
    chk($sformatf("v%0d_csum_pre", idx), checksum, v.exp_csum);
    send(v.cbyte, v.stall);
    host_valid = 1'b0;
    chk($sformatf("v%0d_run", idx), cpu_run, v.exp_run);
    chk($sformatf("v%0d_done", idx), load_done, v.exp_run);
    chk($sformatf("v%0d_err", idx), load_err, !v.exp_run);
    chk($sformatf("v%0d_ready", idx), host_ready, 0);
    chk($sformatf("v%0d_csum", idx), checksum, v.exp_csum);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = AW'(a);
      #1;
      chk($sformatf("v%0d_fetch%0d", idx, a), instr_out, v.exp_run ? v.prog[a*8 +: 8] : 8'h00);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[0].prog[i*8 +: 8] = good_bytes[i];
      vecs[1].prog[i*8 +: 8] = good_bytes[i];
      vecs[2].prog[i*8 +: 8] = good_bytes[i];
      vecs[3].prog[i*8 +: 8] = 8'hFF;
    end
    vecs[0].cbyte = 8'h1F; vecs[0].stall = 0; vecs[0].exp_run = 1; vecs[0].exp_csum = 8'h1F;
    vecs[1].cbyte = 8'h0B; vecs[1].stall = 0; vecs[1].exp_run = 0; vecs[1].exp_csum = 8'h1F;
    vecs[2].cbyte = 8'h1F; vecs[2].stall = 1; vecs[2].exp_run = 1; vecs[2].exp_csum = 8'h1F;
    vecs[3].cbyte = 8'hF0; vecs[3].stall = 0; vecs[3].exp_run = 1; vecs[3].exp_csum = 8'hF0;

    // Reset with start and host_valid asserted.
    rst_n      = 1'b0;
    start      = 1'b1;
    host_valid = 1'b1;
    host_data  = 8'h55;
    fetch_addr = 4'd3;
    tick;
    tick;
    chk("reset_ctl", {host_ready, cpu_run, load_done, load_err}, 0);
    chk("reset_csum", checksum, 0);
    chk("reset_instr", instr_out, 0);

    // IDLE ignores host_valid.
    rst_n = 1'b1;
    start = 1'b0;
    tick;
    chk("idle_ready", host_ready, 0);
    chk("idle_csum", checksum, 0);
    host_valid = 1'b0;

    // Good, bad, stalled-good, wrap-sum loads.
    for (int i = 0; i < 4; i++) begin
      do_start($sformatf("v%0d_start", i));
      load_body(vecs[i], i);
    end

    // Reload from RUN: run drops the cycle after start.
    do_start("reload");

    // Restart mid-load: the byte sent with start is dropped.
    for (int i = 0; i < 7; i++) send(8'h05, 0);
    host_valid = 1'b0;
    chk("partial_csum", checksum, 8'h23);
    start      = 1'b1;
    host_valid = 1'b1;
    host_data  = 8'hFF;
    tick;
    start      = 1'b0;
    host_valid = 1'b0;
    chk("restart_csum", checksum, 0);
    chk("restart_ready", host_ready, 1);
    load_body(vecs[0], 4);

    // Reset mid-load returns to IDLE.
    do_start("rst_mid_start");
    for (int i = 0; i < 3; i++) send(8'h11, 0);
    host_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_mid_ctl", {host_ready, cpu_run, load_done, load_err}, 0);
    chk("rst_mid_csum", checksum, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
